arm_pipe_ctrl: RTL and testbench
================================

Name: arm_pipe_ctrl

Overview:
- Parametrised pipeline-control core for the ARM datapath. It carries per-instruction control and payload from decode through STAGES registered back-end stages (EXE/MEM/WB at default).
- Generates the hazard/freeze signal that stalls the IF and ID stage registers, and inserts bubbles on RAW hazards and taken branches.
- Optionally produces forwarding selects so that only load-use hazards stall.

Parameters:
- STAGES, 3, number of back-end pipeline stages tracked; legal 2..8.
- DATA_W, 32, payload width (result value carried with each instruction).
- REG_AW, 4, register-index width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decode stage holds a real instruction.
- in_wb_en  in  1  the instruction writes a register.
- in_mem_r_en  in  1  the instruction is a load.
- in_dest  in  REG_AW  destination register.
- in_data  in  DATA_W  payload entering stage 0.
- src_1  in  REG_AW  first source register of the decode instruction.
- src_2  in  REG_AW  second source register.
- two_src  in  1  src_2 is used.
- branch_taken  in  1  branch resolved taken this cycle.
- stage_data_upd  in  DATA_W  result computed in stage 0 (EXE), written into stage 0's payload on advance to stage 1.
- hazard  out  1  freeze IF/ID registers this cycle.
- stage_valid  out  STAGES  valid bit per stage; bit 0 is youngest.
- wb_valid  out  1  final stage valid and wb_en.
- wb_dest  out  REG_AW  final-stage destination.
- wb_value  out  DATA_W  final-stage payload.
- fwd_sel_1  out  $clog2(STAGES+1)  forwarding select for src_1.
- fwd_sel_2  out  $clog2(STAGES+1)  forwarding select for src_2.
- stall_cnt  out  CNT_W  count of cycles with hazard=1.

Behaviour:
- Reset (async, rst=1): all stage valid, wb_en, mem_r_en, dest and data bits clear to 0; stall_cnt=0. Outputs during reset: hazard=0, wb_valid=0, fwd_sel_*=0.
- Each stage k holds {valid, wb_en, mem_r_en, dest, data}. Stages never stall; the back end always advances one stage per clock.
- Stage 0 load rule: if in_valid & ~hazard & ~branch_taken, stage 0 loads the inputs with valid=1; otherwise it loads a bubble (valid=0, wb_en=0).
- Stage advance: stage k loads stage k-1 for k>=1. Stage 1 takes data from stage_data_upd rather than stage 0's stored data.
- Match(s, k) = stage_valid[k] & wb_en[k] & dest[k]==s.
- Raw hazard without forwarding: in_valid & (any k Match(src_1,k) | two_src & any k Match(src_2,k)).
- All STAGES stages are checked. The register file writes at the edge that retires the final stage, so the final stage is still a hazard source.
- hazard = raw & ~branch_taken. Branch has priority: it flushes ID, so no freeze is raised.
- Simultaneous hazard and in_valid=0: hazard=0.
- Bubble latency: an instruction stalled on a producer in stage k issues at most STAGES-k cycles later.
- stall_cnt increments on every cycle with hazard=1 and saturates at all-ones (no wrap).
- Outputs: wb_valid = stage_valid[STAGES-1] & wb_en[STAGES-1]; wb_dest and wb_value come directly from final-stage registers. Latency from in_valid acceptance to wb_valid is STAGES cycles.
- Reset asserted mid-operation: all in-flight instructions are discarded immediately.

Optional Feature:
- Macro: ARM_PIPE_FORWARD_EN.
- With the macro defined, fwd_sel_x selects the youngest matching stage, k+1 for stage k, where k>=1 (stage 0 data is not yet available); 0 means the register file.
- With the macro defined, hazard is raised only when there is a Match in stage 0 and that stage has mem_r_en=1 (load-use), or when the only match is in stage 0.
- Without the macro, fwd_sel_1 and fwd_sel_2 are tied to 0 and the full raw rule applies.

Decomposition:
- Package arm_pipe_pkg holds:
  - typedef stage_ctrl_t {valid, wb_en, mem_r_en, dest};
  - constant FWD_RF=0;
  - function for select width.
- One sub-module, arm_hazard_cmp: combinational compare of one source against all stages. It returns any-match and youngest-match index, and is instantiated twice (src_1, src_2).

Test Plan:
- Reset: assert rst mid-stream with 3 valid stages -> stage_valid=000, wb_valid=0 and stall_cnt=0 asynchronously, before the next edge.
- Back-to-back dependency, no forwarding: ADD dest=R2, then SUB src_1=R2 -> hazard=1 for 3 cycles, stall_cnt=3, then SUB enters stage 0; wb_value of the ADD is observed first.
- Branch priority: dependency pending and branch_taken=1 in the same cycle -> hazard=0, and stage 0 loads a bubble.
- two_src=0 with src_2=R5 matching stage 1 -> hazard=0.
- With ARM_PIPE_FORWARD_EN: producer dest=R3 in stage 1, consumer src_1=R3 -> hazard=0 and fwd_sel_1=2.
- With ARM_PIPE_FORWARD_EN, load-use: load dest=R3 in stage 0 with mem_r_en=1, consumer src_1=R3 -> hazard=1 for one cycle, then fwd_sel_1=2.
- Saturation: with CNT_W=4, force 20 hazard cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and helpers for the ARM pipeline-control slice.
package arm_pipe_pkg;

   localparam int DEST_W_MAX = 8;
   localparam int FWD_RF     = 0;

   typedef struct packed {
      logic                  valid;
      logic                  wb_en;
      logic                  mem_r_en;
      logic [DEST_W_MAX-1:0] dest;
   } stage_ctrl_t;

   function automatic int sel_width(input int stages);
      return $clog2(stages + 1);
   endfunction

   function automatic int idx_width(input int stages);
      return (stages > 1) ? $clog2(stages) : 1;
   endfunction

endpackage

// File: rtl/arm_hazard_cmp.sv
// Compares one decode source register against every tracked back-end stage.
module arm_hazard_cmp
   import arm_pipe_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int REG_AW = 4
)(
   input  logic [REG_AW-1:0]             src,
   input  stage_ctrl_t                   ctrl [STAGES],
   output logic                          any_match,
   output logic                          stage0_match,
   output logic                          older_match,
   output logic [idx_width(STAGES)-1:0]  young_idx
);

   localparam int IDX_W = idx_width(STAGES);

   logic [STAGES-1:0] match_s;

   // per-stage match and youngest forwardable (k>=1) match index
   always_comb begin
      match_s   = '0;
      young_idx = '0;
      for (int k = 0; k < STAGES; k++) begin
         match_s[k] = ctrl[k].valid & ctrl[k].wb_en &
                      (ctrl[k].dest == DEST_W_MAX'(src));
      end
      // descending scan so the smallest matching k wins
      for (int k = STAGES - 1; k >= 1; k--) begin
         young_idx = match_s[k] ? IDX_W'(k) : young_idx;
      end
      any_match    = |match_s;
      stage0_match = match_s[0];
      older_match  = |match_s[STAGES-1:1];
   end

endmodule

// File: rtl/arm_pipe_ctrl.sv
// Back-end pipeline control: stage tracking, freeze/bubble generation and stall counting.
// Optional operand forwarding selected by the ARM_PIPE_FORWARD_EN macro.
module arm_pipe_ctrl
   import arm_pipe_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_wb_en,
   input  logic                         in_mem_r_en,
   input  logic [REG_AW-1:0]            in_dest,
   input  logic [DATA_W-1:0]            in_data,
   input  logic [REG_AW-1:0]            src_1,
   input  logic [REG_AW-1:0]            src_2,
   input  logic                         two_src,
   input  logic                         branch_taken,
   input  logic [DATA_W-1:0]            stage_data_upd,
   output logic                         hazard,
   output logic [STAGES-1:0]            stage_valid,
   output logic                         wb_valid,
   output logic [REG_AW-1:0]            wb_dest,
   output logic [DATA_W-1:0]            wb_value,
   output logic [sel_width(STAGES)-1:0] fwd_sel_1,
   output logic [sel_width(STAGES)-1:0] fwd_sel_2,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int SEL_W = sel_width(STAGES);
   localparam int IDX_W = idx_width(STAGES);
`ifdef ARM_PIPE_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   stage_ctrl_t       ctrl_r [STAGES];
   logic [DATA_W-1:0] data_r [STAGES];

   logic              any1_s, s0m1_s, old1_s;
   logic              any2_s, s0m2_s, old2_s;
   logic [IDX_W-1:0]  idx1_s, idx2_s;
   logic              haz1_s, haz2_s;

   arm_hazard_cmp #(.STAGES(STAGES), .REG_AW(REG_AW)) u_cmp_1 (
      .src(src_1), .ctrl(ctrl_r), .any_match(any1_s),
      .stage0_match(s0m1_s), .older_match(old1_s), .young_idx(idx1_s)
   );

   arm_hazard_cmp #(.STAGES(STAGES), .REG_AW(REG_AW)) u_cmp_2 (
      .src(src_2), .ctrl(ctrl_r), .any_match(any2_s),
      .stage0_match(s0m2_s), .older_match(old2_s), .young_idx(idx2_s)
   );

   // hazard and forwarding selects; with forwarding only a stage-0 producer can stall
   always_comb begin
      haz1_s    = FWD_EN ? (s0m1_s & (ctrl_r[0].mem_r_en | ~old1_s)) : any1_s;
      haz2_s    = FWD_EN ? (s0m2_s & (ctrl_r[0].mem_r_en | ~old2_s)) : any2_s;
      hazard    = in_valid & (haz1_s | (two_src & haz2_s)) & ~branch_taken;
      fwd_sel_1 = (FWD_EN && old1_s) ? SEL_W'(idx1_s) + SEL_W'(1) : SEL_W'(FWD_RF);
      fwd_sel_2 = (FWD_EN && old2_s) ? SEL_W'(idx2_s) + SEL_W'(1) : SEL_W'(FWD_RF);
   end

   // output views of the stage registers
   always_comb begin
      stage_valid = '0;
      for (int k = 0; k < STAGES; k++) begin
         stage_valid[k] = ctrl_r[k].valid;
      end
      wb_valid = ctrl_r[STAGES-1].valid & ctrl_r[STAGES-1].wb_en;
      wb_dest  = ctrl_r[STAGES-1].dest[REG_AW-1:0];
      wb_value = data_r[STAGES-1];
   end

   // stage shift register and saturating stall counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            ctrl_r[k] <= '0;
            data_r[k] <= '0;
         end
         stall_cnt <= '0;
      end else begin
         if (in_valid && !hazard && !branch_taken) begin
            ctrl_r[0] <= '{valid: 1'b1, wb_en: in_wb_en, mem_r_en: in_mem_r_en,
                           dest: DEST_W_MAX'(in_dest)};
            data_r[0] <= in_data;
         end else begin
            ctrl_r[0] <= '0;
            data_r[0] <= '0;
         end
         // the EXE result replaces the decode payload on the way into stage 1
         ctrl_r[1] <= ctrl_r[0];
         data_r[1] <= stage_data_upd;
         for (int k = 2; k < STAGES; k++) begin
            ctrl_r[k] <= ctrl_r[k-1];
            data_r[k] <= data_r[k-1];
         end
         if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// Directed self-checking bench for arm_pipe_ctrl (default build and ARM_PIPE_FORWARD_EN build).
module tb_arm_pipe_ctrl;

`ifdef ARM_PIPE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid, in_wb_en, in_mem_r_en, two_src, branch_taken;
   logic [3:0]  in_dest, src_1, src_2;
   logic [31:0] in_data, stage_data_upd;

   logic        hazard, wb_valid;
   logic [2:0]  stage_valid;
   logic [3:0]  wb_dest;
   logic [31:0] wb_value;
   logic [1:0]  fwd_sel_1, fwd_sel_2;
   logic [15:0] stall_cnt;

   logic        hazard_4, wb_valid_4;
   logic [2:0]  stage_valid_4;
   logic [3:0]  wb_dest_4;
   logic [31:0] wb_value_4;
   logic [1:0]  fwd_sel_1_4, fwd_sel_2_4;
   logic [3:0]  stall_cnt_4;

   int n_cmp;
   int n_err;
   int exp_stall;

   arm_pipe_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_wb_en(in_wb_en),
      .in_mem_r_en(in_mem_r_en), .in_dest(in_dest), .in_data(in_data),
      .src_1(src_1), .src_2(src_2), .two_src(two_src), .branch_taken(branch_taken),
      .stage_data_upd(stage_data_upd), .hazard(hazard), .stage_valid(stage_valid),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_value(wb_value),
      .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2), .stall_cnt(stall_cnt)
   );

   arm_pipe_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_wb_en(in_wb_en),
      .in_mem_r_en(in_mem_r_en), .in_dest(in_dest), .in_data(in_data),
      .src_1(src_1), .src_2(src_2), .two_src(two_src), .branch_taken(branch_taken),
      .stage_data_upd(stage_data_upd), .hazard(hazard_4), .stage_valid(stage_valid_4),
      .wb_valid(wb_valid_4), .wb_dest(wb_dest_4), .wb_value(wb_value_4),
      .fwd_sel_1(fwd_sel_1_4), .fwd_sel_2(fwd_sel_2_4), .stall_cnt(stall_cnt_4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic wb, input logic ld, input logic [3:0] d,
                        input logic [31:0] dat, input logic [3:0] s1,
                        input logic [3:0] s2, input logic two);
      in_valid    = 1'b1;
      in_wb_en    = wb;
      in_mem_r_en = ld;
      in_dest     = d;
      in_data     = dat;
      src_1       = s1;
      src_2       = s2;
      two_src     = two;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      idle();
      repeat (4) tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      issue(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
      idle();
      branch_taken   = 1'b0;
      stage_data_upd = 32'd0;

      tick();
      tick();
      check_val("rst_hazard", {31'd0, hazard}, 32'd0);
      check_val("rst_stage_valid", {29'd0, stage_valid}, 32'd0);
      check_val("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check_val("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check_val("rst_fwd_sel_1", {30'd0, fwd_sel_1}, 32'd0);
      check_val("rst_fwd_sel_2", {30'd0, fwd_sel_2}, 32'd0);
      #3 rst = 1'b0;
      tick();

      // ADD R2 then dependent SUB on R2
      issue(1'b1, 1'b0, 4'd2, 32'h11, 4'd0, 4'd0, 1'b0);
      #1 check_val("dep_add_nohaz", {31'd0, hazard}, 32'd0);
      tick();
      issue(1'b1, 1'b0, 4'd4, 32'h22, 4'd2, 4'd0, 1'b0);
      stage_data_upd = 32'hADD0_0002;
      #1 check_val("dep_sv_s0", {29'd0, stage_valid}, 32'b001);
      check_val("dep_haz_s0", {31'd0, hazard}, 32'd1);
      tick();
`ifndef ARM_PIPE_FORWARD_EN
      check_val("dep_haz_s1", {31'd0, hazard}, 32'd1);
      check_val("dep_cnt_1", {16'd0, stall_cnt}, 32'd1);
      check_val("dep_sv_s1", {29'd0, stage_valid}, 32'b010);
      tick();
      stage_data_upd = 32'h5B00_0004;
      check_val("dep_haz_s2", {31'd0, hazard}, 32'd1);
      check_val("dep_cnt_2", {16'd0, stall_cnt}, 32'd2);
      check_val("dep_add_wb_valid", {31'd0, wb_valid}, 32'd1);
      check_val("dep_add_wb_dest", {28'd0, wb_dest}, 32'd2);
      check_val("dep_add_wb_value", wb_value, 32'hADD0_0002);
      tick();
      check_val("dep_haz_clear", {31'd0, hazard}, 32'd0);
      check_val("dep_cnt_3", {16'd0, stall_cnt}, 32'd3);
      check_val("dep_sv_empty", {29'd0, stage_valid}, 32'b000);
      tick();
      idle();
      check_val("dep_sub_in_s0", {29'd0, stage_valid}, 32'b001);
      tick();
      tick();
      check_val("dep_sub_wb_valid", {31'd0, wb_valid}, 32'd1);
      check_val("dep_sub_wb_dest", {28'd0, wb_dest}, 32'd4);
      check_val("dep_sub_wb_value", wb_value, 32'h5B00_0004);
      exp_stall = 3;
`else
      check_val("dep_fwd_nohaz", {31'd0, hazard}, 32'd0);
      check_val("dep_fwd_sel", {30'd0, fwd_sel_1}, 32'd2);
      check_val("dep_fwd_cnt", {16'd0, stall_cnt}, 32'd1);
      exp_stall = 1;
`endif
      check_val("dep_cnt_hold", {16'd0, stall_cnt}, exp_stall);
      drain();

      // branch priority over a pending dependency
      issue(1'b1, 1'b0, 4'd6, 32'h66, 4'd0, 4'd0, 1'b0);
      tick();
      issue(1'b1, 1'b0, 4'd7, 32'h33, 4'd6, 4'd0, 1'b0);
      branch_taken = 1'b1;
      #1 check_val("br_haz", {31'd0, hazard}, 32'd0);
      tick();
      branch_taken = 1'b0;
      check_val("br_bubble", {29'd0, stage_valid}, 32'b010);
      check_val("br_cnt", {16'd0, stall_cnt}, exp_stall);
      idle();
      #1 check_val("inv0_haz", {31'd0, hazard}, 32'd0);
      drain();

      // src_2 only counts when two_src is set
      issue(1'b1, 1'b0, 4'd5, 32'h44, 4'd0, 4'd0, 1'b0);
      tick();
      idle();
      tick();
      issue(1'b1, 1'b0, 4'd8, 32'h55, 4'd7, 4'd5, 1'b0);
      #1 check_val("two0_haz", {31'd0, hazard}, 32'd0);
      two_src = 1'b1;
      #1 check_val("two1_haz", {31'd0, hazard}, FWD ? 32'd0 : 32'd1);
      check_val("two1_sel2", {30'd0, fwd_sel_2}, FWD ? 32'd2 : 32'd0);
      check_val("two1_sel1", {30'd0, fwd_sel_1}, 32'd0);
      drain();

      // producer in stage 1
      issue(1'b1, 1'b0, 4'd3, 32'h77, 4'd0, 4'd0, 1'b0);
      tick();
      idle();
      tick();
      issue(1'b1, 1'b0, 4'd9, 32'h88, 4'd3, 4'd0, 1'b0);
      #1 check_val("fwd_s1_haz", {31'd0, hazard}, FWD ? 32'd0 : 32'd1);
      check_val("fwd_s1_sel", {30'd0, fwd_sel_1}, FWD ? 32'd2 : 32'd0);
      drain();

      // load-use on stage 0
      issue(1'b1, 1'b1, 4'd3, 32'h99, 4'd0, 4'd0, 1'b0);
      tick();
      issue(1'b1, 1'b0, 4'd9, 32'hAA, 4'd3, 4'd0, 1'b0);
      #1 check_val("ld_use_haz", {31'd0, hazard}, 32'd1);
      tick();
      check_val("ld_use_haz2", {31'd0, hazard}, FWD ? 32'd0 : 32'd1);
      check_val("ld_use_sel", {30'd0, fwd_sel_1}, FWD ? 32'd2 : 32'd0);
      drain();

      // asynchronous reset with three live stages
      issue(1'b1, 1'b0, 4'd8, 32'h61, 4'd0, 4'd0, 1'b0);
      tick();
      issue(1'b1, 1'b0, 4'd9, 32'h62, 4'd0, 4'd0, 1'b0);
      tick();
      issue(1'b1, 1'b0, 4'd10, 32'h63, 4'd0, 4'd0, 1'b0);
      tick();
      idle();
      check_val("mid_sv_full", {29'd0, stage_valid}, 32'b111);
      check_val("mid_wb_valid", {31'd0, wb_valid}, 32'd1);
      #1 rst = 1'b1;
      #1 check_val("mid_rst_sv", {29'd0, stage_valid}, 32'd0);
      check_val("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
      check_val("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
      check_val("mid_rst_haz", {31'd0, hazard}, 32'd0);
      #2 rst = 1'b0;

      // repeated self-dependent loads to saturate the 4-bit counter
      issue(1'b1, 1'b1, 4'd1, 32'h0, 4'd1, 4'd0, 1'b0);
      repeat (48) tick();
      check_val("sat_cnt4", {28'd0, stall_cnt_4}, 32'd15);
      check_val("sat_cnt16", {16'd0, stall_cnt}, FWD ? 32'd24 : 32'd36);
      repeat (8) tick();
      check_val("sat_cnt4_hold", {28'd0, stall_cnt_4}, 32'd15);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
